// File: rtl/legv8_lsu_pkg.sv
// Shared types and address-map constants for the LEGv8 load/store unit.
// Byte-lane mapping and alignment helpers used by legv8_lsu.
package lsu_pkg;

  localparam logic [63:0] LSU_BEGINNING_DATA = 64'h0000_0000_1001_0000;
  localparam logic [63:0] LSU_END_DATA       = 64'h0000_0000_1001_FFFF;

  typedef enum logic [2:0] {
    LDUR, LDURSW, LDURH, LDURB, STUR, STURW, STURH, STURB
  } lsu_op_t;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} lsu_state_t;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} lsu_size_t;

  typedef struct packed {
    logic [7:0] be;
    logic [2:0] lane;
  } lsu_lane_t;

  function automatic lsu_size_t op_size(lsu_op_t op);
    case (op)
      LDURB, STURB:  return SZ_B;
      LDURH, STURH:  return SZ_H;
      LDURSW, STURW: return SZ_W;
      default:       return SZ_D;
    endcase
  endfunction

  function automatic logic op_is_store(lsu_op_t op);
    return (op == STUR) || (op == STURW) || (op == STURH) || (op == STURB);
  endfunction

  // Lane base drops the offset bits below the access size, forcing natural alignment.
  function automatic lsu_lane_t lane_map(lsu_size_t sz, logic [2:0] off);
    lsu_lane_t m;
    case (sz)
      SZ_B: begin
        m.lane = off;
        m.be   = 8'b0000_0001 << off;
      end
      SZ_H: begin
        m.lane = {off[2:1], 1'b0};
        m.be   = 8'b0000_0011 << m.lane;
      end
      SZ_W: begin
        m.lane = {off[2], 2'b00};
        m.be   = 8'h0F << m.lane;
      end
      default: begin
        m.lane = 3'b000;
        m.be   = 8'hFF;
      end
    endcase
    return m;
  endfunction

  function automatic logic misaligned(lsu_size_t sz, logic [2:0] off);
    case (sz)
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      SZ_W:    return |off[1:0];
      default: return |off;
    endcase
  endfunction

endpackage

// File: rtl/legv8_lsu_if.sv
// Data-memory port between the LSU (master) and the synchronous data memory (slave).
interface legv8_lsu_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  oMemReadEnable;
  logic                  oMemWriteEnable;
  logic [7:0]            oMemByteEnable;
  logic [DATA_WIDTH-1:0] oMemAddress;
  logic [DATA_WIDTH-1:0] oMemWriteData;
  logic [DATA_WIDTH-1:0] iMemReadData;

  modport master (
    output oMemReadEnable, oMemWriteEnable, oMemByteEnable, oMemAddress, oMemWriteData,
    input  iMemReadData
  );

  modport slave (
    input  oMemReadEnable, oMemWriteEnable, oMemByteEnable, oMemAddress, oMemWriteData,
    output iMemReadData
  );
endinterface

// File: rtl/legv8_lsu_load_align.sv
// Combinational load alignment: shift captured word down to its lane, then zero/sign extend.
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic [DATA_WIDTH-1:0] i_data,
  input  lsu_op_t               i_op,
  input  logic [2:0]            i_lane,
  output logic [DATA_WIDTH-1:0] o_data
);
  logic [DATA_WIDTH-1:0] w_shifted;

  always_comb begin
    w_shifted = i_data >> {i_lane, 3'b000};
    case (i_op)
      LDURB:   o_data = DATA_WIDTH'(w_shifted[7:0]);
      LDURH:   o_data = DATA_WIDTH'(w_shifted[15:0]);
      LDURSW:  o_data = DATA_WIDTH'($signed(w_shifted[31:0]));
      default: o_data = w_shifted;
    endcase
  end
endmodule

// File: rtl/legv8_lsu.sv
// LEGv8 load/store initiator: issues one memory access per request and returns extended load data.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned accesses instead of forcing natural alignment.
module legv8_lsu
  import lsu_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 64,
  parameter int                    READ_LATENCY   = 1,
  parameter logic [DATA_WIDTH-1:0] BEGINNING_DATA = LSU_BEGINNING_DATA,
  parameter logic [DATA_WIDTH-1:0] END_DATA       = LSU_END_DATA
) (
  input  logic                  iCLK,
  input  logic                  iRST_n,
  input  logic                  iReq,
  input  lsu_op_t               iOp,
  input  logic [DATA_WIDTH-1:0] iAddr,
  input  logic [DATA_WIDTH-1:0] iStoreData,
  output logic                  oBusy,
  output logic                  oDone,
  output logic [DATA_WIDTH-1:0] oLoadData,
  output logic                  oFault,
  legv8_lsu_if.master           mem
);
  lsu_state_t            r_state, w_state_nxt;
  lsu_op_t               r_op;
  logic [DATA_WIDTH-1:0] r_addr, r_wdata, r_load_data, w_aligned;
  logic [7:0]            r_be;
  logic [2:0]            r_lane;
  logic [1:0]            r_cnt;
  logic                  r_fault, w_fault, w_misalign, w_last;
  lsu_size_t             w_size;
  lsu_lane_t             w_map;

  always_comb begin
    w_size = op_size(iOp);
    w_map  = lane_map(w_size, iAddr[2:0]);
`ifdef LSU_MISALIGN_TRAP_EN
    w_misalign = misaligned(w_size, iAddr[2:0]);
`else
    w_misalign = 1'b0;
`endif
    w_fault = (iAddr < BEGINNING_DATA) || (iAddr > END_DATA) || w_misalign;
  end

  assign w_last = (r_cnt == 2'(READ_LATENCY - 1));

  lsu_load_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .i_data (mem.iMemReadData),
    .i_op   (r_op),
    .i_lane (r_lane),
    .o_data (w_aligned)
  );

  always_comb begin
    w_state_nxt         = r_state;
    oBusy               = 1'b1;
    oDone               = 1'b0;
    oFault              = 1'b0;
    mem.oMemReadEnable  = 1'b0;
    mem.oMemWriteEnable = 1'b0;
    mem.oMemByteEnable  = '0;
    case (r_state)
      IDLE: begin
        oBusy = 1'b0;
        if (iReq) w_state_nxt = w_fault ? RESP : (op_is_store(iOp) ? WRITE : READ);
      end
      READ: begin
        mem.oMemReadEnable = 1'b1;
        mem.oMemByteEnable = r_be;
        if (w_last) w_state_nxt = RESP;
      end
      WRITE: begin
        mem.oMemWriteEnable = 1'b1;
        mem.oMemByteEnable  = r_be;
        w_state_nxt         = RESP;
      end
      RESP: begin
        oDone       = 1'b1;
        oFault      = r_fault;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_state     <= IDLE;
      r_op        <= LDUR;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_load_data <= '0;
      r_be        <= '0;
      r_lane      <= '0;
      r_cnt       <= '0;
      r_fault     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: if (iReq) begin
          r_op    <= iOp;
          r_addr  <= {iAddr[DATA_WIDTH-1:3], 3'b000};
          r_wdata <= iStoreData << {w_map.lane, 3'b000};
          r_be    <= w_map.be;
          r_lane  <= w_map.lane;
          r_fault <= w_fault;
          r_cnt   <= '0;
          if (w_fault || op_is_store(iOp)) r_load_data <= '0;
        end
        READ: begin
          if (w_last) r_load_data <= w_aligned;
          else        r_cnt       <= r_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign mem.oMemAddress   = r_addr;
  assign mem.oMemWriteData = r_wdata;
  assign oLoadData         = r_load_data;

endmodule

// File: tb/tb_legv8_lsu.sv
// Self-checking bench for legv8_lsu: directed cases, async reset during a write, random traffic.
module tb_legv8_lsu;
  import lsu_pkg::*;

  localparam int          L    = 1;
  localparam logic [63:0] BEG  = LSU_BEGINNING_DATA;
  localparam logic [63:0] ENDD = LSU_END_DATA;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0, rst_n = 1'b0, req = 1'b0;
  lsu_op_t     op = LDUR;
  logic [63:0] addr = '0, sdata = '0;
  logic        busy, done, fault;
  logic [63:0] ldata;

  legv8_lsu_if #(.DATA_WIDTH(64)) mif ();

  legv8_lsu #(.DATA_WIDTH(64), .READ_LATENCY(L)) dut (
    .iCLK(clk), .iRST_n(rst_n), .iReq(req), .iOp(op), .iAddr(addr), .iStoreData(sdata),
    .oBusy(busy), .oDone(done), .oLoadData(ldata), .oFault(fault), .mem(mif)
  );

  always #5 clk = ~clk;

  // ---------------- memory model (environment) ----------------
  logic [63:0] mem [0:8191];
  bit          touched [0:8191];
  logic        bd_we = 1'b0;
  logic [12:0] bd_idx = '0;
  logic [63:0] bd_data = '0;
  logic [63:0] mw;
  int unsigned rdcnt = 0;

  function automatic logic [63:0] seed(int unsigned idx);
    return {idx * 32'h9E37_79B1, ~(idx * 32'h85EB_CA6B)};
  endfunction

  function automatic logic in_mem(logic [63:0] a);
    return (a >= BEG) && (a <= ENDD);
  endfunction

  function automatic logic [63:0] mem_word(logic [12:0] i);
    return touched[i] ? mem[i] : seed(32'(i));
  endfunction

  always @(posedge clk) begin
    if (bd_we) begin
      mem[bd_idx]     <= bd_data;
      touched[bd_idx] <= 1'b1;
    end else if (mif.oMemWriteEnable && in_mem(mif.oMemAddress)) begin
      mw = mem_word(mif.oMemAddress[15:3]);
      for (int b = 0; b < 8; b++)
        if (mif.oMemByteEnable[b]) mw[8*b +: 8] = mif.oMemWriteData[8*b +: 8];
      mem[mif.oMemAddress[15:3]]     <= mw;
      touched[mif.oMemAddress[15:3]] <= 1'b1;
    end
    rdcnt <= mif.oMemReadEnable ? rdcnt + 1 : 0;
  end

  assign mif.iMemReadData = (mif.oMemReadEnable && rdcnt == L - 1 && in_mem(mif.oMemAddress))
                            ? mem_word(mif.oMemAddress[15:3]) : 'x;

  // ---------------- reference model and checking ----------------
  logic [63:0] ref_mem [0:8191];
  int          checks = 0, failures = 0;

  logic        e_fault;
  logic [7:0]  e_be;
  logic [63:0] e_addr, e_wdata, e_ldata;
  int unsigned e_cycle, e_re, e_we;
  logic [12:0] e_idx;
  bit          e_store;

  int unsigned o_cycle, o_re, o_we;
  logic [7:0]  o_be;
  logic [63:0] o_addr, o_wdata, o_ldata;
  logic        o_fault, o_got, o_bad;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model(input lsu_op_t o, input logic [63:0] a, input logic [63:0] d);
    int unsigned n, lane;
    logic [63:0] eff, w, v;
    case (o)
      LDURB, STURB:  n = 1;
      LDURH, STURH:  n = 2;
      LDURSW, STURW: n = 4;
      default:       n = 8;
    endcase
    e_store = (o == STUR) || (o == STURW) || (o == STURH) || (o == STURB);
    e_fault = !(a >= BEG && a <= ENDD) || (TRAP && (a % n) != 0);
    eff     = a - (a % n);
    lane    = 32'(eff % 8);
    e_be    = 8'((1 << n) - 1) << lane;
    e_addr  = eff - lane;
    e_wdata = d << (8 * lane);
    e_cycle = e_fault ? 2 : (e_store ? 3 : 2 + L);
    e_re    = (!e_fault && !e_store) ? L : 0;
    e_we    = (!e_fault && e_store) ? 1 : 0;
    e_idx   = eff[15:3];
    e_ldata = '0;
    if (!e_fault && e_store) begin
      w = ref_mem[e_idx];
      for (int unsigned i = 0; i < n; i++) w[8*(lane+i) +: 8] = d[8*i +: 8];
      ref_mem[e_idx] = w;
    end else if (!e_fault) begin
      v = ref_mem[e_idx] >> (8 * lane);
      if (n < 8) v = v % (64'd1 << (8 * n));
      if (o == LDURSW && v >= 64'h8000_0000) v = v | 64'hFFFF_FFFF_0000_0000;
      e_ldata = v;
    end
  endtask

  // Called at a negedge while the DUT is idle; returns at the negedge after oDone.
  task automatic do_req(input lsu_op_t o, input logic [63:0] a, input logic [63:0] d);
    model(o, a, d);
    chk("idle_busy", busy, 1'b0);
    op = o; addr = a; sdata = d; req = 1'b1;
    o_cycle = 1; o_re = 0; o_we = 0; o_be = '0; o_addr = '0; o_wdata = '0;
    o_ldata = '0; o_fault = 1'b0; o_got = 1'b0; o_bad = 1'b0;
    while (!o_got && o_cycle < 20) begin
      @(negedge clk);
      o_cycle++;
      if (mif.oMemReadEnable) begin
        o_re++; o_be = mif.oMemByteEnable; o_addr = mif.oMemAddress;
      end
      if (mif.oMemWriteEnable) begin
        o_we++; o_be = mif.oMemByteEnable; o_addr = mif.oMemAddress; o_wdata = mif.oMemWriteData;
      end
      if (done) begin
        o_got = 1'b1; o_fault = fault; o_ldata = ldata;
        if (mif.oMemReadEnable || mif.oMemWriteEnable) o_bad = 1'b1;
        req = 1'b0;
      end else if (!busy) o_bad = 1'b1;
    end
    req = 1'b0;
    chk("done_seen", o_got, 1'b1);
    chk("done_cycle", o_cycle, e_cycle);
    chk("fault", o_fault, e_fault);
    chk("load_data", o_ldata, e_ldata);
    chk("rd_cycles", o_re, e_re);
    chk("wr_cycles", o_we, e_we);
    chk("busy_enables", o_bad, 1'b0);
    if (!e_fault) begin
      chk("byte_en", o_be, e_be);
      chk("mem_addr", o_addr, e_addr);
    end
    if (!e_fault && e_store) chk("wr_data", o_wdata, e_wdata);
    @(negedge clk);
    chk("done_pulse", done, 1'b0);
    if (!e_fault) chk("mem_word", mem_word(e_idx), ref_mem[e_idx]);
  endtask

  task automatic poke(input logic [12:0] i, input logic [63:0] d);
    bd_idx = i; bd_data = d; bd_we = 1'b1;
    @(posedge clk);
    #1 bd_we = 1'b0;
    ref_mem[i] = d;
    @(negedge clk);
  endtask

  logic [63:0] r_sd, r_ad;
  int unsigned r_sel;

  initial begin
    for (int unsigned i = 0; i < 8192; i++) ref_mem[i] = seed(i);

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_fault", fault, 1'b0);
    chk("rst_ldata", ldata, 64'h0);
    chk("rst_re", mif.oMemReadEnable, 1'b0);
    chk("rst_we", mif.oMemWriteEnable, 1'b0);
    chk("rst_be", mif.oMemByteEnable, 8'h00);
    chk("rst_addr", mif.oMemAddress, 64'h0);
    chk("rst_wdata", mif.oMemWriteData, 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // directed cases
    poke(13'd0, 64'h8877_6655_4433_2211);
    do_req(LDURB, BEG + 5, 64'h0);
    chk("d1_be", o_be, 8'h20);
    chk("d1_ldata", o_ldata, 64'h66);
    chk("d1_cycle", o_cycle, 3);
    chk("d1_re", o_re, 1);

    poke(13'd0, 64'h8000_0001_0000_0000);
    do_req(LDURSW, BEG + 4, 64'h0);
    chk("d2_be", o_be, 8'hF0);
    chk("d2_ldata", o_ldata, 64'hFFFF_FFFF_8000_0001);

    do_req(STURH, BEG + 2, 64'hABCD);
    chk("d3_we", o_we, 1);
    chk("d3_be", o_be, 8'h0C);
    chk("d3_wdata", o_wdata, 64'hABCD_0000);
    chk("d3_cycle", o_cycle, 3);

    do_req(LDUR, ENDD + 1, 64'h0);
    chk("d4_fault", o_fault, 1'b1);
    chk("d4_cycle", o_cycle, 2);
    chk("d4_enables", o_re + o_we, 0);
    chk("d4_ldata", o_ldata, 64'h0);

    do_req(STUR, BEG + 3, 64'h0123_4567_89AB_CDEF);
    chk("d5_fault", o_fault, TRAP);
    chk("d5_we", o_we, TRAP ? 0 : 1);

    do_req(LDURB, ENDD, 64'h0);
    do_req(LDURB, BEG - 1, 64'h0);
    do_req(LDUR, BEG, 64'h0);
    do_req(STURB, ENDD, 64'h5A);

    // async reset in the middle of a write: no write, no done, then read old contents
    op = STUR; addr = BEG + 64; sdata = 64'hDEAD_BEEF_CAFE_F00D; req = 1'b1;
    @(negedge clk);
    chk("rst_mid_we_before", mif.oMemWriteEnable, 1'b1);
    rst_n = 1'b0; req = 1'b0;
    #1;
    chk("rst_mid_we", mif.oMemWriteEnable, 1'b0);
    chk("rst_mid_be", mif.oMemByteEnable, 8'h00);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_done", done, 1'b0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_done_after", done, 1'b0);
    chk("rst_mid_mem", mem_word(13'd8), ref_mem[8]);
    do_req(LDUR, BEG + 64, 64'h0);

    // random traffic
    for (int k = 0; k < 80; k++) begin
      r_sel = $urandom_range(0, 9);
      if (r_sel == 0)      r_ad = BEG - 1 - 64'($urandom_range(0, 100));
      else if (r_sel == 1) r_ad = ENDD + 1 + 64'($urandom_range(0, 100));
      else if (r_sel == 2) r_ad = BEG + 64'($urandom_range(0, 63));
      else                 r_ad = BEG + 64'($urandom_range(0, 16'hFFFF));
      r_sd = {$urandom, $urandom};
      do_req(lsu_op_t'($urandom_range(0, 7)), r_ad, r_sd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/legv8_lsu.md
Name: legv8_lsu

Overview:
- Load/store initiator for the LEGv8 datapath; the requester side of the data memory port.
- Takes one LDUR*/STUR* request from the execute/memory stage and drives the memory's read enable, write enable, byte enable, address and write data.
- Waits out the memory's synchronous read latency, then returns lane-aligned, zero- or sign-extended load data.
- Holds the datapath with oBusy while an access is in flight.

Parameters:
DATA_WIDTH, 64, width of data bus and addresses
READ_LATENCY, 1, memory clocks from read enable asserted to iMemReadData valid (legal 1..3)
BEGINNING_DATA, 64'h0000_0000_1001_0000, first byte address of user data memory
END_DATA, 64'h0000_0000_1001_FFFF, last byte address of user data memory

Ports:
iCLK  in  1  system clock, all state on rising edge
iRST_n  in  1  asynchronous active-low reset
iReq  in  1  request strobe from datapath, sampled only in IDLE
iOp  in  3  lsu_op_t: LDUR, LDURSW, LDURH, LDURB, STUR, STURW, STURH, STURB
iAddr  in  64  byte address
iStoreData  in  64  store source register, value right-justified
oBusy  out  1  access in flight; datapath stalls
oDone  out  1  one-cycle pulse: access complete
oLoadData  out  64  extended load result, valid while oDone=1
oFault  out  1  one-cycle pulse with oDone: access rejected, no memory cycle
oMemReadEnable  out  1  to memory read enable
oMemWriteEnable  out  1  to memory write enable
oMemByteEnable  out  8  to memory byte enables; bit n means byte lane n
oMemAddress  out  64  to memory address, always aligned to 8 bytes
oMemWriteData  out  64  to memory write data, shifted to lane
iMemReadData  in  64  from memory read data; don't-care (possibly Z) except at capture

Behaviour:
- Reset (async, iRST_n=0):
  - State goes to IDLE.
  - All outputs go to 0; oMemAddress and oMemWriteData also 0.
  - Latency counter clears.
  - An in-flight write is dropped; the enable deasserts immediately and no partial-cycle retry follows.
- States: IDLE, READ, WRITE, RESP.
- IDLE:
  - On iReq=1, latch iOp, iAddr and iStoreData; oBusy=1 from the next cycle.
  - Decode of the latched op:
    - Fault: go to RESP.
    - Load: go to READ.
    - Store: go to WRITE.
- Fault conditions:
  - Address outside [BEGINNING_DATA, END_DATA], inclusive both ends.
  - Misalignment, see the Optional Feature section.
- Byte offset is off = addr[2:0], little-endian lanes.
  - Byte access: lane off, 8'b1<<off.
  - Half access: 8'b11<<{off[2:1],1'b0}.
  - Word access: 8'h0F<<{off[2],2'b0}.
  - Doubleword access: 8'hFF.
- oMemAddress = {addr[63:3],3'b000}.
- oMemWriteData = iStoreData << (8*lane_base).
- READ:
  - oMemReadEnable=1 and byte enables held for exactly READ_LATENCY cycles (counter).
  - On the last cycle, capture iMemReadData, then go to RESP.
- WRITE:
  - oMemWriteEnable=1 for exactly one iCLK cycle, then go to RESP.
  - A write is never issued twice per request.
- RESP:
  - oDone=1 for one cycle; oBusy=1 still; then return to IDLE.
  - In IDLE, oBusy=0; back-to-back requests therefore cost at least 1 IDLE cycle.
- Load extension applies to the captured word >> (8*lane_base):
  - LDURB: zero-extend 8 bits.
  - LDURH: zero-extend 16 bits.
  - LDURSW: sign-extend bit 31.
  - LDUR: full 64 bits.
- oLoadData is 0 for stores and faults, and holds its last value otherwise (valid only at oDone).
- Latency: a load completes at cycle 1+READ_LATENCY+1 after the accepted iReq; a store at cycle 3; a fault at cycle 2.
- iReq while oBusy=1 is ignored; the datapath contract is to hold iReq until oDone.
- Enables never assert in IDLE or RESP.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined: a misaligned access causes oFault with no memory cycle.
  - Half misaligned: off[0]≠0.
  - Word misaligned: off[1:0]≠0.
  - Doubleword misaligned: off≠0.
- Undefined: the low offset bits below the access size are silently cleared (natural alignment forced) and the access proceeds; oFault then reports only out-of-range addresses.

Decomposition:
- Package lsu_pkg holds:
  - lsu_op_t enum.
  - lsu_state_t enum.
  - Access-size typedef (B/H/W/D).
  - Function computing byte-enable and lane base from size and offset.
- BEGINNING_DATA and END_DATA come from the shared parameters header.
- One natural sub-module, lsu_load_align: purely combinational shift and extend from captured data, op and offset; unit-testable alone.

Test Plan:
- LDURB, addr BEGINNING_DATA+5, memory word 64'h8877_6655_4433_2211, READ_LATENCY=1 -> oMemByteEnable=8'h20, oMemReadEnable high 1 cycle, oDone at cycle 3, oLoadData=64'h66.
- LDURSW, addr BEGINNING_DATA+4, memory 64'h8000_0001_0000_0000 -> byte enable 8'hF0, oLoadData=64'hFFFF_FFFF_8000_0001.
- STURH, addr BEGINNING_DATA+2, iStoreData=64'hABCD -> one cycle with oMemWriteEnable=1, byte enable 8'h0C, write data 64'hABCD_0000, oDone at cycle 3.
- LDUR, addr END_DATA+1 -> no enables ever asserted, oFault=oDone=1 at cycle 2, oLoadData=0.
- STUR, addr BEGINNING_DATA+3:
  - With LSU_MISALIGN_TRAP_EN: oFault, no write.
  - Without it: write to BEGINNING_DATA, byte enable 8'hFF.
- Pulse iRST_n low during WRITE cycle -> oMemWriteEnable drops immediately, state IDLE, no oDone; a subsequent LDUR reads the pre-reset memory contents.
